// File: rtl/regbank_pkg.sv
// Shared types and helpers for the AXI4-Lite register bank.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } r_state_t;

    typedef enum logic [2:0] {
        KIND_CTRL,
        KIND_STAT,
        KIND_IRQS,
        KIND_IRQE,
        KIND_BAD
    } reg_kind_t;

    // Decoded register: which bank it lives in and the offset inside that bank.
    typedef struct packed {
        reg_kind_t  kind;
        logic [4:0] index;
    } reg_dec_t;

    // Map a word index onto ctrl / stat / irq banks; anything else is BAD.
    function automatic reg_dec_t decode_idx(input logic [31:0] addr_word,
                                            input int unsigned num_ctrl,
                                            input int unsigned num_stat,
                                            input bit          irq_en);
        reg_dec_t d;
        d.kind  = KIND_BAD;
        d.index = '0;
        if (addr_word < num_ctrl) begin
            d.kind  = KIND_CTRL;
            d.index = 5'(addr_word);
        end else if (addr_word < num_ctrl + num_stat) begin
            d.kind  = KIND_STAT;
            d.index = 5'(addr_word - num_ctrl);
        end else if (irq_en && (addr_word == num_ctrl + num_stat)) begin
            d.kind  = KIND_IRQS;
        end else if (irq_en && (addr_word == num_ctrl + num_stat + 1)) begin
            d.kind  = KIND_IRQE;
        end
        return d;
    endfunction

    // Expand a 4-bit byte strobe into a 32-bit lane mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

    // Replace only the strobed byte lanes of old_val with new_val.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] m;
        m = strb_mask(strb);
        return (old_val & ~m) | (new_val & m);
    endfunction

endpackage

// File: rtl/regbank_irq.sv
// Sticky interrupt status (W1C) with enable mask and registered irq output.
// Latency: status/enable update on the write edge; irq follows one cycle later.
// Backpressure: none; writes are single-cycle strobes from the bank's commit.
module regbank_irq
    import regbank_pkg::*;
#(
    parameter int IRQ_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IRQ_WIDTH-1:0] irq_src,
    input  logic                 wr_status,
    input  logic                 wr_enable,
    input  logic [31:0]          wr_data,
    input  logic [3:0]           wr_strb,
    output logic [31:0]          status_rd,
    output logic [31:0]          enable_rd,
    output logic                 irq
);

    logic [IRQ_WIDTH-1:0] status_q;
    logic [IRQ_WIDTH-1:0] enable_q;
    logic [31:0]          clear_word;
    logic [31:0]          enable_word;
    logic [IRQ_WIDTH-1:0] clear_bits;
    logic                 unused_hi_bits;

    // Build the W1C clear mask and the strobe-merged enable value.
    always_comb begin
        clear_word  = wr_status ? (wr_data & strb_mask(wr_strb)) : 32'h0;
        enable_word = strb_merge(32'(enable_q), wr_data, wr_strb);
        clear_bits  = clear_word[IRQ_WIDTH-1:0];
    end

    assign unused_hi_bits = ^{clear_word, enable_word};
    assign status_rd      = 32'(status_q);
    assign enable_rd      = 32'(enable_q);

    // Sticky status: a source set in the same cycle as a clear keeps the bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status_q <= '0;
            enable_q <= '0;
            irq      <= 1'b0;
        end else begin
            status_q <= (status_q & ~clear_bits) | irq_src;
            if (wr_enable) begin
                enable_q <= enable_word[IRQ_WIDTH-1:0];
            end
            irq <= |(status_q & enable_q);
        end
    end

endmodule

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: R/W ctrl regs, RO status regs, optional irq block (REGBANK_IRQ_EN).
// Latency: write commits on the completing AW/W edge, B one cycle later; R data one cycle after AR.
// Backpressure: one outstanding write and one outstanding read; readies drop until B/R is taken.
module axi_lite_regbank
    import regbank_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 6,
    parameter int          NUM_CTRL           = 4,
    parameter int          NUM_STAT           = 2,
    parameter logic [31:0] CTRL_RESET_VAL     = 32'h0,
    parameter int          IRQ_WIDTH          = 8
) (
    input  logic                                     s00_axi_aclk,
    input  logic                                     s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            s00_axi_awaddr,
    input  logic [2:0]                               s00_axi_awprot,
    input  logic                                     s00_axi_awvalid,
    output logic                                     s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          s00_axi_wstrb,
    input  logic                                     s00_axi_wvalid,
    output logic                                     s00_axi_wready,
    output logic [1:0]                               s00_axi_bresp,
    output logic                                     s00_axi_bvalid,
    input  logic                                     s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            s00_axi_araddr,
    input  logic [2:0]                               s00_axi_arprot,
    input  logic                                     s00_axi_arvalid,
    output logic                                     s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]            s00_axi_rdata,
    output logic [1:0]                               s00_axi_rresp,
    output logic                                     s00_axi_rvalid,
    input  logic                                     s00_axi_rready,
    output logic [32*NUM_CTRL-1:0]                   ctrl_regs,
    output logic [NUM_CTRL-1:0]                      ctrl_wr_pulse,
    input  logic [32*((NUM_STAT > 0) ? NUM_STAT : 1)-1:0] stat_in
`ifdef REGBANK_IRQ_EN
    ,
    input  logic [IRQ_WIDTH-1:0]                     irq_src,
    output logic                                     irq
`endif
);

`ifdef REGBANK_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif
    localparam int NUM_REGS = NUM_CTRL + NUM_STAT + (IRQ_EN ? 2 : 0);

    // Reject configurations the address map or the 32-bit datapath cannot hold.
    generate
        if (C_S_AXI_DATA_WIDTH != 32 || NUM_CTRL < 1 || NUM_CTRL > 16 ||
            NUM_STAT < 0 || NUM_STAT > 16 || IRQ_WIDTH < 1 || IRQ_WIDTH > 32 ||
            NUM_REGS > (1 << (C_S_AXI_ADDR_WIDTH - 2))) begin : g_bad_cfg
            $error("axi_lite_regbank: illegal parameter combination");
        end
    endgenerate

    // ---------------- write path ----------------
    w_state_t                      w_state, w_state_nxt;
    logic                          aw_hs, w_hs, commit, wr_ok;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q, cm_addr;
    logic [31:0]                   w_data_q, cm_data;
    logic [3:0]                    w_strb_q, cm_strb;
    reg_dec_t                      wr_dec;
    logic [31:0]                   ctrl_q [NUM_CTRL];
    logic [NUM_CTRL-1:0]           pulse_q;
    logic                          bvalid_q;
    logic [1:0]                    bresp_q;

    // Readies are gated by reset so nothing handshakes while it is held.
    assign s00_axi_awready = s00_axi_aresetn && (w_state == W_IDLE || w_state == W_HAVE_DATA);
    assign s00_axi_wready  = s00_axi_aresetn && (w_state == W_IDLE || w_state == W_HAVE_ADDR);
    assign aw_hs           = s00_axi_awvalid && s00_axi_awready;
    assign w_hs            = s00_axi_wvalid && s00_axi_wready;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign ctrl_wr_pulse   = pulse_q;

    // Next write state, commit detection and selection of latched vs live AW/W.
    always_comb begin
        w_state_nxt = w_state;
        commit      = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit      = 1'b1;
                    w_state_nxt = W_RESP;
                end else if (aw_hs) begin
                    w_state_nxt = W_HAVE_ADDR;
                end else if (w_hs) begin
                    w_state_nxt = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (w_hs) begin
                    commit      = 1'b1;
                    w_state_nxt = W_RESP;
                end
            end
            W_HAVE_DATA: begin
                if (aw_hs) begin
                    commit      = 1'b1;
                    w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (s00_axi_bready) begin
                    w_state_nxt = W_IDLE;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
        cm_addr = (w_state == W_HAVE_ADDR) ? aw_addr_q : s00_axi_awaddr;
        cm_data = (w_state == W_HAVE_DATA) ? w_data_q  : s00_axi_wdata;
        cm_strb = (w_state == W_HAVE_DATA) ? w_strb_q  : s00_axi_wstrb;
        wr_dec  = decode_idx(32'(cm_addr[C_S_AXI_ADDR_WIDTH-1:2]), NUM_CTRL, NUM_STAT, IRQ_EN);
        wr_ok   = (wr_dec.kind != KIND_STAT) && (wr_dec.kind != KIND_BAD);
    end

    // Write FSM state register.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_nxt;
        end
    end

    // Hold whichever half of the write arrived first, and drive the B channel.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_addr_q <= s00_axi_awaddr;
            end
            if (w_hs) begin
                w_data_q <= s00_axi_wdata;
                w_strb_q <= s00_axi_wstrb;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_q && s00_axi_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Control registers and their write pulses; an all-zero strobe changes nothing.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            for (int k = 0; k < NUM_CTRL; k++) begin
                ctrl_q[k] <= CTRL_RESET_VAL;
            end
            pulse_q <= '0;
        end else begin
            pulse_q <= '0;
            if (commit && wr_dec.kind == KIND_CTRL) begin
                for (int k = 0; k < NUM_CTRL; k++) begin
                    if (wr_dec.index == 5'(k)) begin
                        ctrl_q[k]  <= strb_merge(ctrl_q[k], cm_data, cm_strb);
                        pulse_q[k] <= |cm_strb;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_flat
        assign ctrl_regs[32*g +: 32] = ctrl_q[g];
    end

    // ---------------- optional interrupt block ----------------
`ifdef REGBANK_IRQ_EN
    logic [31:0] irq_status;
    logic [31:0] irq_enable;

    regbank_irq #(
        .IRQ_WIDTH(IRQ_WIDTH)
    ) u_irq (
        .clk       (s00_axi_aclk),
        .rst_n     (s00_axi_aresetn),
        .irq_src   (irq_src),
        .wr_status (commit && wr_dec.kind == KIND_IRQS),
        .wr_enable (commit && wr_dec.kind == KIND_IRQE),
        .wr_data   (cm_data),
        .wr_strb   (cm_strb),
        .status_rd (irq_status),
        .enable_rd (irq_enable),
        .irq       (irq)
    );
`endif

    // ---------------- read path ----------------
    r_state_t    r_state, r_state_nxt;
    logic        ar_hs;
    reg_dec_t    rd_dec;
    logic [31:0] rd_val;
    logic [1:0]  rd_resp;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        rvalid_q;
    logic        unused_inputs;

    assign s00_axi_arready = s00_axi_aresetn && (r_state == R_IDLE);
    assign ar_hs           = s00_axi_arvalid && s00_axi_arready;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = rresp_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign unused_inputs   = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_araddr[1:0],
                               cm_addr[1:0], stat_in};

    // Read decode and data mux; ctrl values are the registered (pre-write) ones.
    always_comb begin
        rd_dec  = decode_idx(32'(s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2]), NUM_CTRL, NUM_STAT, IRQ_EN);
        rd_val  = 32'h0;
        rd_resp = RESP_SLVERR;
        case (rd_dec.kind)
            KIND_CTRL: begin
                rd_resp = RESP_OKAY;
                for (int k = 0; k < NUM_CTRL; k++) begin
                    if (rd_dec.index == 5'(k)) rd_val = ctrl_q[k];
                end
            end
            KIND_STAT: begin
                rd_resp = RESP_OKAY;
                for (int s = 0; s < NUM_STAT; s++) begin
                    if (rd_dec.index == 5'(s)) rd_val = stat_in[32*s +: 32];
                end
            end
`ifdef REGBANK_IRQ_EN
            KIND_IRQS: begin
                rd_resp = RESP_OKAY;
                rd_val  = irq_status;
            end
            KIND_IRQE: begin
                rd_resp = RESP_OKAY;
                rd_val  = irq_enable;
            end
`endif
            default: ;
        endcase
    end

    // Next read state: one outstanding read, released by the R handshake.
    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)          r_state_nxt = R_RESP;
            R_RESP:  if (s00_axi_rready) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_nxt;
        end
    end

    // R channel: capture data on AR handshake, hold it until the R handshake.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
        end else if (ar_hs) begin
            rdata_q  <= rd_val;
            rresp_q  <= rd_resp;
            rvalid_q <= 1'b1;
        end else if (rvalid_q && s00_axi_rready) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed bench for axi_lite_regbank; B/R responses checked by a queue-based monitor.
// Latency: n/a.
// Backpressure: exercised by holding bready low and by out-of-order AW/W.
module tb_axi_lite_regbank;
    import regbank_pkg::*;

    logic         clk = 1'b0;
    logic         aresetn;
    logic [5:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [127:0] ctrl_regs;
    logic [3:0]   ctrl_wr_pulse;
    logic [63:0]  stat_in;
`ifdef REGBANK_IRQ_EN
    logic [7:0]   irq_src;
    logic         irq;
`endif

    int checks   = 0;
    int failures = 0;
    int pulse_cnt [4] = '{default: 0};

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        string       name;
    } exp_t;
    exp_t b_q[$];
    exp_t r_q[$];

    always #5 clk = ~clk;

    axi_lite_regbank dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (aresetn),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .ctrl_regs       (ctrl_regs),
        .ctrl_wr_pulse   (ctrl_wr_pulse),
        .stat_in         (stat_in)
`ifdef REGBANK_IRQ_EN
        ,
        .irq_src         (irq_src),
        .irq             (irq)
`endif
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic note_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout waiting for DUT handshake", name);
    endtask

    // Count write pulses so each test can check how many fired.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) pulse_cnt[k] += int'(ctrl_wr_pulse[k]);
    end

    // Scoreboard monitor: compare every B/R beat against the oldest expectation.
    always @(negedge clk) begin
        exp_t be, re;
        if (aresetn && bvalid && bready) begin
            if (b_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_b actual=bresp %0h required=no response", bresp);
            end else begin
                be = b_q.pop_front();
                check({be.name, ".bresp"}, bresp, be.resp);
            end
        end
        if (aresetn && rvalid && rready) begin
            if (r_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_r actual=rdata %h required=no response", rdata);
            end else begin
                re = r_q.pop_front();
                check({re.name, ".rdata"}, rdata, re.data);
                check({re.name, ".rresp"}, rresp, re.resp);
            end
        end
    end

    // Present AW and W together; returns just after the edge completing both.
    task automatic issue_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_done = 0, w_done = 0, af, wf;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
            @(negedge clk);
            af = awvalid && awready;
            wf = wvalid && wready;
            @(posedge clk); #1;
            if (af) begin aw_done = 1; awvalid = 1'b0; end
            if (wf) begin w_done = 1; wvalid = 1'b0; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_done && w_done)) note_timeout("aw_w");
    endtask

    task automatic finish_b();
        bit done = 0, f;
        bready = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            f = bvalid;
            @(posedge clk); #1;
            if (f) done = 1;
        end
        bready = 1'b0;
        if (!done) note_timeout("b");
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] resp, input string name);
        b_q.push_back('{data: 32'h0, resp: resp, name: name});
        issue_write(a, d, s);
        finish_b();
    endtask

    task automatic axi_read(input logic [5:0] a, input logic [31:0] d, input logic [1:0] resp,
                            input string name);
        bit done = 0, f;
        r_q.push_back('{data: d, resp: resp, name: name});
        araddr = a; arvalid = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            f = arvalid && arready;
            @(posedge clk); #1;
            if (f) done = 1;
        end
        arvalid = 1'b0;
        if (!done) note_timeout({name, ".ar"});
        done = 0;
        rready = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            f = rvalid;
            @(posedge clk); #1;
            if (f) done = 1;
        end
        rready = 1'b0;
        if (!done) note_timeout({name, ".r"});
    endtask

    initial begin
        int p0;
        aresetn = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = '0; wstrb = '0;
        stat_in = {32'h12345678, 32'hCAFE0001};
`ifdef REGBANK_IRQ_EN
        irq_src = '0;
`endif
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_handshakes", {awready, wready, arready, bvalid, rvalid}, 5'b0);
        check("rst_resp_data", {bresp, rresp, rdata}, 36'h0);
        check("rst_ctrl_regs", ctrl_regs, 128'h0);
        check("rst_pulse", ctrl_wr_pulse, 4'h0);
        aresetn = 1'b1;
        @(negedge clk);
        check("first_ready", {awready, wready, arready}, 3'b111);
        @(posedge clk); #1;

        // Basic write/readback of all ctrl registers.
        for (int k = 0; k < 4; k++)
            axi_write(6'(4*k), 32'(k + 1), 4'hF, RESP_OKAY, $sformatf("wr_ctrl%0d", k));
        for (int k = 0; k < 4; k++)
            axi_read(6'(4*k), 32'(k + 1), RESP_OKAY, $sformatf("rd_ctrl%0d", k));
        check("pulse_once", {8'(pulse_cnt[3]), 8'(pulse_cnt[2]), 8'(pulse_cnt[1]), 8'(pulse_cnt[0])},
              32'h01010101);

        // Read and write of the same ctrl register on the same edge.
        fork
            axi_write(6'h04, 32'h5A5A5A5A, 4'hF, RESP_OKAY, "same_edge_wr");
            axi_read(6'h04, 32'h00000002, RESP_OKAY, "same_edge_rd");
        join
        axi_read(6'h04, 32'h5A5A5A5A, RESP_OKAY, "after_same_edge");

        // Byte-strobe merge.
        axi_write(6'h00, 32'hAABBCCDD, 4'hF, RESP_OKAY, "strb_full");
        axi_write(6'h00, 32'h11223344, 4'b0101, RESP_OKAY, "strb_0101");
        axi_read(6'h00, 32'hAA22CC44, RESP_OKAY, "strb_readback");
        check("pulse_reg0_cnt", pulse_cnt[0], 3);

        // Zero strobe: OKAY, no change, no pulse.
        axi_write(6'h08, 32'hFFFFFFFF, 4'h0, RESP_OKAY, "strb_zero");
        axi_read(6'h08, 32'h00000003, RESP_OKAY, "strb_zero_rd");
        check("strb_zero_nopulse", pulse_cnt[2], 1);

        // W three cycles ahead of AW, then B held off by bready.
        wdata = 32'hDEAD0055; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        check("w_first_ready", wready, 1'b1);
        @(posedge clk); #1;
        wvalid = 1'b0;
        @(negedge clk);
        check("have_data_rdy", {awready, wready}, 2'b10);
        repeat (2) @(posedge clk);
        #1;
        awaddr = 6'h0C; awvalid = 1'b1;
        @(negedge clk);
        check("bvalid_before_aw", bvalid, 1'b0);
        @(posedge clk); #1;
        awvalid = 1'b0;
        @(negedge clk);
        check("bvalid_rise", bvalid, 1'b1);
        check("late_aw_pulse", ctrl_wr_pulse, 4'b1000);
        check("late_aw_data", ctrl_regs[127:96], 32'hDEAD0055);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check($sformatf("b_hold%0d", n), {bvalid, bresp, awready, wready}, 5'b10000);
        end
        @(posedge clk); #1;
        b_q.push_back('{data: 32'h0, resp: RESP_OKAY, name: "late_aw_b"});
        finish_b();

        // Status registers and illegal accesses.
        p0 = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3];
        axi_read(6'h10, 32'hCAFE0001, RESP_OKAY, "rd_stat0");
        axi_read(6'h14, 32'h12345678, RESP_OKAY, "rd_stat1");
        axi_write(6'h10, 32'h0BADF00D, 4'hF, RESP_SLVERR, "wr_stat0");
        axi_read(6'h10, 32'hCAFE0001, RESP_OKAY, "rd_stat0_again");
        axi_read(6'h3C, 32'h0, RESP_SLVERR, "rd_oor");
        axi_write(6'h3C, 32'h0BADF00D, 4'hF, RESP_SLVERR, "wr_oor");
        axi_read(6'h13, 32'hCAFE0001, RESP_OKAY, "rd_low_bits");
`ifndef REGBANK_IRQ_EN
        axi_read(6'h18, 32'h0, RESP_SLVERR, "rd_irq_absent");
        axi_write(6'h1C, 32'h1, 4'hF, RESP_SLVERR, "wr_irq_absent");
`endif
        check("slverr_nochange", ctrl_regs, {32'hDEAD0055, 32'h3, 32'h5A5A5A5A, 32'hAA22CC44});
        check("slverr_nopulse", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3], p0);

        // Reset while a write sits in W_HAVE_ADDR and a read sits in R_RESP.
        awaddr = 6'h04; awvalid = 1'b1;
        araddr = 6'h00; arvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        check("pre_rst_state", {awready, wready, arready, rvalid}, 4'b0101);
        @(posedge clk); #1;
        aresetn = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_handshakes", {awready, wready, arready, bvalid, rvalid}, 5'b0);
        check("mid_rst_ctrl", ctrl_regs, 128'h0);
        @(posedge clk); #1;
        aresetn = 1'b1;
        axi_write(6'h04, 32'h00000077, 4'hF, RESP_OKAY, "post_rst_wr");
        axi_read(6'h04, 32'h00000077, RESP_OKAY, "post_rst_rd1");
        axi_read(6'h00, 32'h0, RESP_OKAY, "post_rst_rd0");

`ifdef REGBANK_IRQ_EN
        // Interrupt: enable, pulse, W1C racing a new pulse, then a clean clear.
        axi_write(6'h1C, 32'h1, 4'hF, RESP_OKAY, "irq_en_wr");
        irq_src = 8'h01;
        @(posedge clk); #1;
        irq_src = 8'h00;
        check("irq_one_edge", irq, 1'b0);
        @(posedge clk); #1;
        check("irq_two_edges", irq, 1'b1);
        irq_src = 8'h01;
        b_q.push_back('{data: 32'h0, resp: RESP_OKAY, name: "w1c_race"});
        issue_write(6'h18, 32'h1, 4'hF);
        irq_src = 8'h00;
        finish_b();
        axi_read(6'h18, 32'h1, RESP_OKAY, "irq_stat_kept");
        check("irq_after_race", irq, 1'b1);
        b_q.push_back('{data: 32'h0, resp: RESP_OKAY, name: "w1c_clear"});
        issue_write(6'h18, 32'h1, 4'hF);
        check("irq_clear_edge", irq, 1'b1);
        @(posedge clk); #1;
        check("irq_cleared", irq, 1'b0);
        finish_b();
        axi_read(6'h18, 32'h0, RESP_OKAY, "irq_stat_zero");
        axi_read(6'h1C, 32'h1, RESP_OKAY, "irq_en_rd");
`endif

        // Drain: every queued expectation must have been matched.
        for (int n = 0; n < 20 && (b_q.size() != 0 || r_q.size() != 0); n++) @(posedge clk);
        check("b_queue_empty", b_q.size(), 0);
        check("r_queue_empty", r_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_lite_regbank.md
Name: axi_lite_regbank

Overview:
Parametrised AXI4-Lite slave register bank. It replaces the fixed four-register slave in our Pmod peripheral IPs.
- Configurable count of read/write control registers and read-only hardware status registers.
- Byte-strobe writes, AW and W accepted in any order.
- SLVERR on illegal accesses.
- Per-register write pulses to the user logic, such as the I2S2 core.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data width; only 32 is legal.
C_S_AXI_ADDR_WIDTH, 6, byte address width; requires NUM_CTRL+NUM_STAT(+2 if IRQ) <= 2^(C_S_AXI_ADDR_WIDTH-2).
NUM_CTRL, 4, number of R/W control registers, 1..16.
NUM_STAT, 2, number of read-only status registers, 0..16.
CTRL_RESET_VAL, 32'h0, reset value of every control register.
IRQ_WIDTH, 8, interrupt source count (only used with REGBANK_IRQ_EN), 1..32.

Ports:
s00_axi_aclk  in  1  clock
s00_axi_aresetn  in  1  synchronous reset, active-low
s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid / s00_axi_awready  in/out  1  AW handshake
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte enables
s00_axi_wvalid / s00_axi_wready  in/out  1  W handshake
s00_axi_bresp  out  2  write response
s00_axi_bvalid / s00_axi_bready  out/in  1  B handshake
s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid / s00_axi_arready  in/out  1  AR handshake
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  read response
s00_axi_rvalid / s00_axi_rready  out/in  1  R handshake
ctrl_regs  out  32*NUM_CTRL  flattened control registers; reg k at [32k+31:32k]
ctrl_wr_pulse  out  NUM_CTRL  one-cycle pulse, set in the cycle after reg k is written (OKAY writes only)
stat_in  in  32*max(NUM_STAT,1)  status values, sampled at AR handshake

Behaviour:
- Address map: word index = addr[ADDR_W-1:2]; addr[1:0] ignored.
  - Index 0..NUM_CTRL-1: ctrl.
  - Index NUM_CTRL..NUM_CTRL+NUM_STAT-1: stat.
  - Any other index is out of range.
- Reset (s00_axi_aresetn=0 at a rising edge):
  - All ready/valid outputs 0; bresp=rresp=0; rdata=0.
  - ctrl_regs=CTRL_RESET_VAL; pulses 0.
  - Write and read FSMs go to IDLE; in-flight transactions are dropped without response.
  - The first handshake is possible on the first edge after release.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - awready=1 in W_IDLE and W_HAVE_DATA; wready=1 in W_IDLE and W_HAVE_ADDR; both 0 in W_RESP.
  - W_IDLE: AW only -> W_HAVE_ADDR (latch addr). W only -> W_HAVE_DATA (latch data/strb). Both in the same cycle -> commit.
  - Commit happens on the edge of the completing handshake:
    - Byte lanes with wstrb[i]=1 are updated; the others are kept.
    - bvalid=1 from the next cycle; state goes to W_RESP.
  - W_RESP: hold bvalid and bresp until bready; then go to W_IDLE. A same-cycle new AW/W is not accepted.
  - bresp=OKAY (2'b00) for ctrl indices. bresp=SLVERR (2'b10) for stat or out-of-range indices, which are not written.
  - wstrb=0 to a ctrl register gives OKAY, with no data change and no pulse.
- Read FSM states: R_IDLE (arready=1), R_RESP (arready=0).
  - On the AR handshake edge, rdata/rresp are loaded and rvalid=1 from the next cycle.
  - rdata is held stable until the rready handshake, then the FSM returns to R_IDLE.
  - Read latency is one cycle after AR handshake; back-to-back reads achieve one per two cycles.
  - Out of range: rdata=0, rresp=SLVERR.
- Read and write to the same ctrl index on the same edge: read returns the pre-write value.
- The write and read FSMs are fully independent; one outstanding transaction each.

Optional Feature:
REGBANK_IRQ_EN:
- Defined:
  - Adds ports irq_src (in, IRQ_WIDTH) and irq (out, 1).
  - Adds register IRQ_STATUS at index NUM_CTRL+NUM_STAT: sticky, set by irq_src bit high, cleared by writing 1 (W1C, respects wstrb). Set wins over a same-cycle clear.
  - Adds register IRQ_ENABLE at index +1: R/W, reset 0.
  - irq is registered: irq = |(IRQ_STATUS & IRQ_ENABLE), one cycle after the status/enable change.
- Undefined: these indices are out of range (SLVERR); ports are absent.

Decomposition:
- Package regbank_pkg holds:
  - Response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Write and read FSM state enums.
  - Function decode_idx(addr) -> {kind: CTRL/STAT/IRQS/IRQE/BAD, index}.
  - Function strb_merge(old, new, strb).
- Sub-module regbank_irq: sticky/W1C/enable/irq-output logic, instantiated only under REGBANK_IRQ_EN.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC then read back -> each read returns the written value with OKAY; ctrl_wr_pulse[k] fires once per write.
- Write 0xAABBCCDD then write 0x11223344 with wstrb=4'b0101 to 0x0 -> readback 0xAA22CC44.
- W sent 3 cycles before AW, then AW with no W -> both complete; bvalid rises one cycle after the last handshake; bready held low 5 cycles keeps bvalid and bresp stable.
- With NUM_CTRL=4 and stat_in[0]=0xCAFE0001: read 0x10 -> 0xCAFE0001 OKAY; write 0x10 -> SLVERR, no change; read 0x3C -> 0x0 SLVERR.
- Deassert s00_axi_aresetn while in W_HAVE_ADDR and R_RESP -> next cycle all valid/ready outputs 0 and ctrl_regs=CTRL_RESET_VAL; a fresh write completes normally.
- With REGBANK_IRQ_EN: enable=0x1, pulse irq_src[0] -> irq=1 after 2 edges; W1C 0x1 on the same cycle as a new pulse -> status stays 1; a later W1C clears it and irq=0 the cycle after.
